// File: rtl/mac_ucode_decoder_pkg.sv
// Shared encodings for the MAC loop microcode decoder.
// Indices and instruction layout match the microcode compiler's encoder.
package mac_ucode_decoder_pkg;

    localparam int MAC_UCODE_INSN_W = 6;

    // Offset register indices (src 0..3, dst 0..3)
    localparam int MAC_UCODE_A_OFFS = 0;
    localparam int MAC_UCODE_B_OFFS = 1;
    localparam int MAC_UCODE_C_OFFS = 2;
    localparam int MAC_UCODE_D_OFFS = 3;

    // Read-only mnemonic register indices, addressed as src = MAC_UCODE_SRC_RO_BASE + index
    localparam int MAC_UCODE_MNEM_NBITER     = 0;
    localparam int MAC_UCODE_MNEM_ITERSTRIDE = 1;
    localparam int MAC_UCODE_MNEM_ONESTRIDE  = 2;

    localparam int MAC_UCODE_SRC_RO_BASE = 4;
    localparam int MAC_UCODE_SRC_RSVD    = 7;

    localparam logic MAC_UCODE_MODE_ADD  = 1'b0;
    localparam logic MAC_UCODE_MODE_MOVE = 1'b1;

    typedef struct packed {
        logic       mode;
        logic [1:0] dst;
        logic [2:0] src;
    } mac_ucode_insn_t;

    typedef enum logic [1:0] {
        MAC_UCD_IDLE,
        MAC_UCD_EMIT,
        MAC_UCD_EXEC,
        MAC_UCD_DONE
    } mac_ucd_state_t;

endpackage

// File: rtl/mac_ucode_loop_cnt.sv
// Iteration counters for the whole loop nest (loop 0 innermost).
// Reports which loops are on their last iteration and the lowest loop that can still advance.
module mac_ucode_loop_cnt #(
    parameter int unsigned NB_LOOPS   = 2,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned LOOP_IDX_W = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          init_i,
    input  logic                          step_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_i,
    output logic [NB_LOOPS-1:0]           wrap_o,
    output logic [LOOP_IDX_W-1:0]         sel_o
);

    logic [CNT_WIDTH-1:0] cnt_q [NB_LOOPS];
    logic [CNT_WIDTH-1:0] cnt_d [NB_LOOPS];
    logic [CNT_WIDTH-1:0] rng;
    logic [CNT_WIDTH-1:0] last;
    logic [NB_LOOPS-1:0]  wrap;
    logic [LOOP_IDX_W-1:0] sel;

    // A range of 0 behaves like 1: the loop is always on its last iteration.
    always_comb begin
        wrap = '0;
        rng  = '0;
        last = '0;
        for (int l = 0; l < NB_LOOPS; l++) begin
            rng     = range_i[l*CNT_WIDTH +: CNT_WIDTH];
            last    = (rng == '0) ? rng : rng - 1'b1;
            wrap[l] = (cnt_q[l] >= last);
        end
    end

    always_comb begin
        sel = '0;
        for (int l = NB_LOOPS - 1; l >= 0; l--) begin
            if (!wrap[l]) begin
                sel = LOOP_IDX_W'(l);
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NB_LOOPS; l++) begin
            cnt_d[l] = cnt_q[l];
        end
        if (init_i) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                cnt_d[l] = '0;
            end
        end else if (step_i && !(&wrap)) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                if (l < int'(sel)) begin
                    cnt_d[l] = '0;
                end else if (l == int'(sel)) begin
                    cnt_d[l] = cnt_q[l] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                cnt_q[l] <= '0;
            end
        end else if (clear_i) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                cnt_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    assign wrap_o = wrap;
    assign sel_o  = sel;

endmodule

// File: rtl/mac_ucode_decoder.sv
// MAC loop microcode decoder: walks a loop nest and emits one A/B/C/D offset tuple per
// iteration, running the advancing loop's microcode between tuples.
module mac_ucode_decoder
    import mac_ucode_decoder_pkg::*;
#(
    parameter int unsigned NB_LOOPS   = 2,
    parameter int unsigned NB_INSN    = 8,
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned NB_RO_REG  = 3,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned SLOT_W     = $clog2(NB_INSN),
    parameter int unsigned NBI_W      = $clog2(NB_INSN + 1),
    parameter int unsigned LOOP_IDX_W = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  logic [NB_INSN*MAC_UCODE_INSN_W-1:0] ucode_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]     loop_range_i,
    input  logic [NB_LOOPS*SLOT_W-1:0]        loop_insn_offs_i,
    input  logic [NB_LOOPS*NBI_W-1:0]         loop_nb_insn_i,
    input  logic [NB_RO_REG*REG_WIDTH-1:0]    ro_reg_i,
    input  logic [NB_REG*REG_WIDTH-1:0]       offs_init_i,
    output logic [NB_REG*REG_WIDTH-1:0]       offs_o,
    output logic                              offs_valid_o,
    input  logic                              offs_ready_i,
    output logic                              busy_o,
    output logic                              done_o
);

    mac_ucd_state_t        state_q, state_d;
    logic [REG_WIDTH-1:0]  offs_q [NB_REG];
    logic [REG_WIDTH-1:0]  offs_d [NB_REG];
    logic [SLOT_W-1:0]     pc_q, pc_d;
    logic [NBI_W-1:0]      rem_q, rem_d;

    logic                  cnt_init;
    logic                  cnt_step;
    logic [NB_LOOPS-1:0]   wrap;
    logic [LOOP_IDX_W-1:0] sel;
    logic [SLOT_W-1:0]     sel_slot;
    logic [NBI_W-1:0]      sel_nb;

    mac_ucode_insn_t       insn;
    logic [REG_WIDTH-1:0]  src_val;
    logic [REG_WIDTH-1:0]  result;
    logic [SLOT_W-1:0]     pc_next;

    mac_ucode_loop_cnt #(
        .NB_LOOPS   (NB_LOOPS),
        .CNT_WIDTH  (CNT_WIDTH),
        .LOOP_IDX_W (LOOP_IDX_W)
    ) u_loop_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .init_i  (cnt_init),
        .step_i  (cnt_step),
        .range_i (loop_range_i),
        .wrap_o  (wrap),
        .sel_o   (sel)
    );

    assign sel_slot = loop_insn_offs_i[int'(sel)*SLOT_W +: SLOT_W];
    assign sel_nb   = loop_nb_insn_i[int'(sel)*NBI_W +: NBI_W];
    assign insn     = ucode_i[int'(pc_q)*MAC_UCODE_INSN_W +: MAC_UCODE_INSN_W];
    assign pc_next  = (pc_q == SLOT_W'(NB_INSN - 1)) ? '0 : pc_q + 1'b1;

    always_comb begin
        src_val = '0;
        if (int'(insn.src) < MAC_UCODE_SRC_RO_BASE) begin
            src_val = offs_q[insn.src[1:0]];
        end else if (int'(insn.src) != MAC_UCODE_SRC_RSVD) begin
            src_val = ro_reg_i[(int'(insn.src) - MAC_UCODE_SRC_RO_BASE)*REG_WIDTH +: REG_WIDTH];
        end
        result = (insn.mode == MAC_UCODE_MODE_MOVE) ? src_val : offs_q[insn.dst] + src_val;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rem_d        = rem_q;
        cnt_init     = 1'b0;
        cnt_step     = 1'b0;
        offs_valid_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        for (int i = 0; i < NB_REG; i++) begin
            offs_d[i] = offs_q[i];
        end

        unique case (state_q)
            MAC_UCD_IDLE: begin
                if (start_i) begin
                    for (int i = 0; i < NB_REG; i++) begin
                        offs_d[i] = offs_init_i[i*REG_WIDTH +: REG_WIDTH];
                    end
                    cnt_init = 1'b1;
                    state_d  = MAC_UCD_EMIT;
                end
            end
            MAC_UCD_EMIT: begin
                busy_o       = 1'b1;
                offs_valid_o = 1'b1;
                if (offs_ready_i) begin
                    if (!(&wrap)) begin
                        cnt_step = 1'b1;
                        pc_d     = sel_slot;
                        rem_d    = sel_nb;
                        state_d  = (sel_nb == '0) ? MAC_UCD_EMIT : MAC_UCD_EXEC;
                    end else begin
                        state_d = MAC_UCD_DONE;
                    end
                end
            end
            MAC_UCD_EXEC: begin
                busy_o            = 1'b1;
                offs_d[insn.dst]  = result;
                pc_d              = pc_next;
                rem_d             = rem_q - 1'b1;
                if (rem_q == NBI_W'(1)) begin
                    state_d = MAC_UCD_EMIT;
                end
            end
            MAC_UCD_DONE: begin
                done_o  = 1'b1;
                state_d = MAC_UCD_IDLE;
            end
            default: state_d = MAC_UCD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MAC_UCD_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            for (int i = 0; i < NB_REG; i++) begin
                offs_q[i] <= '0;
            end
        end else if (clear_i) begin
            state_q <= MAC_UCD_IDLE;
            pc_q    <= '0;
            rem_q   <= '0;
            for (int i = 0; i < NB_REG; i++) begin
                offs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rem_q   <= rem_d;
            for (int i = 0; i < NB_REG; i++) begin
                offs_q[i] <= offs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NB_REG; g++) begin : g_offs_out
        assign offs_o[g*REG_WIDTH +: REG_WIDTH] = offs_q[g];
    end

endmodule

// File: tb/tb_mac_ucode_decoder.sv
// Bench for mac_ucode_decoder: directed and random loop nests checked against a tuple-list model.
module tb_mac_ucode_decoder;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic         start_i;
    logic [47:0]  ucode_i;
    logic [31:0]  loop_range_i;
    logic [5:0]   loop_insn_offs_i;
    logic [7:0]   loop_nb_insn_i;
    logic [95:0]  ro_reg_i;
    logic [127:0] offs_init_i;
    logic [127:0] offs_o;
    logic         offs_valid_o;
    logic         offs_ready_i;
    logic         busy_o;
    logic         done_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] exp_q [$];
    int           gap_q [$];

    mac_ucode_decoder dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .ucode_i          (ucode_i),
        .loop_range_i     (loop_range_i),
        .loop_insn_offs_i (loop_insn_offs_i),
        .loop_nb_insn_i   (loop_nb_insn_i),
        .ro_reg_i         (ro_reg_i),
        .offs_init_i      (offs_init_i),
        .offs_o           (offs_o),
        .offs_valid_o     (offs_valid_o),
        .offs_ready_i     (offs_ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int s, input bit mode, input int dst, input int src);
        ucode_i[s*6 +: 6] = {mode, 2'(dst), 3'(src)};
    endtask

    task automatic set_loop(input int l, input int rng, input int offs, input int nb);
        loop_range_i[l*16 +: 16]    = 16'(rng);
        loop_insn_offs_i[l*3 +: 3]  = 3'(offs);
        loop_nb_insn_i[l*4 +: 4]    = 4'(nb);
    endtask

    // Tuple list: iteration t advances the lowest loop whose position in the mixed-radix count
    // rolls over, then that loop's instructions run on a plain register array.
    task automatic build_model();
        int          r [2];
        int          total, l, p, nb, base, slot, dst, src;
        logic [31:0] o [4];
        logic [31:0] v;
        logic [5:0]  w;
        exp_q.delete();
        gap_q.delete();
        for (int k = 0; k < 2; k++) begin
            r[k] = int'(loop_range_i[k*16 +: 16]);
            if (r[k] == 0) r[k] = 1;
        end
        total = r[0] * r[1];
        for (int i = 0; i < 4; i++) o[i] = offs_init_i[i*32 +: 32];
        exp_q.push_back({o[3], o[2], o[1], o[0]});
        gap_q.push_back(1);
        for (int t = 1; t < total; t++) begin
            l = 0;
            p = r[0];
            while (l < 1 && (t % p) == 0) begin
                l++;
                p = p * r[l];
            end
            nb   = int'(loop_nb_insn_i[l*4 +: 4]);
            base = int'(loop_insn_offs_i[l*3 +: 3]);
            for (int k = 0; k < nb; k++) begin
                slot = (base + k) % 8;
                w    = ucode_i[slot*6 +: 6];
                dst  = int'(w[4:3]);
                src  = int'(w[2:0]);
                if (src < 4)      v = o[src];
                else if (src < 7) v = ro_reg_i[(src-4)*32 +: 32];
                else              v = 32'd0;
                o[dst] = w[5] ? v : o[dst] + v;
            end
            exp_q.push_back({o[3], o[2], o[1], o[0]});
            gap_q.push_back(nb + 1);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 5 valid cycles after the
    // 3rd handshake. Returns at the cycle where done_o is expected.
    task automatic run_seq(input int mode, input bit poke);
        int since, hs, stall_left, idx;
        bit fresh, prev_stall, rdy, ended;
        build_model();
        since = 0; hs = 0; stall_left = -1; idx = 0;
        fresh = 1; prev_stall = 0; ended = 0;
        offs_ready_i = 1'b0;
        start_i = 1'b1;
        for (int cyc = 0; cyc < 600 && !ended; cyc++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (idx == exp_q.size()) begin
                chk("done_pulse", {done_o, busy_o, offs_valid_o}, 3'b100);
                offs_ready_i = 1'b0;
                ended = 1;
            end else begin
                since++;
                if (prev_stall) chk("stall_valid", offs_valid_o, 1'b1);
                if (offs_valid_o) begin
                    if (fresh) chk("latency", since, gap_q[idx]);
                    fresh = 0;
                    chk("tuple", offs_o, exp_q[idx]);
                    chk("busy", busy_o, 1'b1);
                    if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                    else if (mode == 2 && stall_left > 0) begin
                        rdy = 0;
                        stall_left--;
                    end else rdy = 1;
                    if (poke && idx == 1) start_i = 1'b1;
                    offs_ready_i = rdy;
                    prev_stall = !rdy;
                    if (rdy) begin
                        idx++;
                        hs++;
                        since = 0;
                        fresh = 1;
                        if (mode == 2 && hs == 3) stall_left = 5;
                    end
                end else begin
                    chk("no_early_done", done_o, 1'b0);
                    offs_ready_i = 1'($urandom_range(0, 1));
                    prev_stall = 0;
                end
            end
        end
        if (!ended) chk("timeout", idx, exp_q.size());
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk_i);
        chk(tag, {done_o, busy_o, offs_valid_o}, 3'b000);
    endtask

    task automatic cfg_two_loops();
        ucode_i = '0; loop_range_i = '0; loop_insn_offs_i = '0; loop_nb_insn_i = '0;
        ro_reg_i = {32'd4, 32'd64, 32'd6};
        offs_init_i = '0;
        set_slot(0, 1'b0, 0, 6);
        set_slot(1, 1'b0, 1, 5);
        set_slot(2, 1'b1, 0, 2);
        set_loop(0, 3, 0, 1);
        set_loop(1, 2, 1, 2);
    endtask

    task automatic abort_at_2nd_tuple();
        cfg_two_loops();
        offs_ready_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_2nd_tuple", {offs_valid_o, offs_o}, {1'b1, 128'h4});
        offs_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; offs_ready_i = 1'b0;
        ucode_i = '0; loop_range_i = '0; loop_insn_offs_i = '0; loop_nb_insn_i = '0;
        ro_reg_i = '0; offs_init_i = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_state", {done_o, busy_o, offs_valid_o, offs_o}, '0);

        // One loop of 4, A += ITERSTRIDE
        ro_reg_i = {32'd4, 32'd16, 32'd4};
        set_slot(0, 1'b0, 0, 5);
        set_loop(0, 4, 0, 1);
        set_loop(1, 1, 0, 0);
        run_seq(0, 0);
        chk_idle("idle_after_t1");

        // Two loops with inner ADD and outer ADD+MOVE, then the same with a 5-cycle stall
        cfg_two_loops();
        run_seq(0, 0);
        chk_idle("idle_after_t2");
        run_seq(2, 0);
        chk_idle("idle_after_stall");

        // All ranges 0: single tuple; a start in the done cycle is ignored, then taken in IDLE
        offs_init_i = {32'h11, 32'h22, 32'h33, 32'h44};
        set_loop(0, 0, 0, 1);
        set_loop(1, 0, 1, 2);
        run_seq(0, 0);
        start_i = 1'b1;
        @(negedge clk_i);
        chk("start_at_done_ignored", {busy_o, offs_valid_o}, 2'b00);
        @(negedge clk_i);
        start_i = 1'b0;
        chk("restart_tuple", {offs_valid_o, offs_o}, {1'b1, offs_init_i});
        offs_ready_i = 1'b1;
        @(negedge clk_i);
        offs_ready_i = 1'b0;
        chk("restart_done", {done_o, busy_o}, 2'b10);
        chk_idle("idle_after_t4");

        // Modulo wrap of A, instruction slots wrapping 7 -> 0, stray start while busy
        ucode_i = '0;
        offs_init_i = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFF0};
        ro_reg_i = {32'd8, 32'h20, 32'd3};
        set_slot(7, 1'b0, 0, 5);
        set_slot(0, 1'b0, 1, 6);
        set_loop(0, 3, 7, 2);
        set_loop(1, 1, 0, 0);
        run_seq(1, 1);
        chk_idle("idle_after_wrap");

        // Soft clear during the 2nd tuple
        abort_at_2nd_tuple();
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("after_clear", {done_o, busy_o, offs_valid_o, offs_o}, '0);
        chk_idle("no_done_after_clear");
        run_seq(0, 0);
        chk_idle("idle_after_clear_run");

        // Async reset during the 2nd tuple
        abort_at_2nd_tuple();
        rst_ni = 1'b0;
        #1;
        chk("in_reset", {done_o, busy_o, offs_valid_o, offs_o}, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_idle("no_done_after_reset");
        run_seq(1, 0);
        chk_idle("idle_after_reset_run");

        // Random nests, microcode, registers and ready pattern
        for (int it = 0; it < 6; it++) begin
            ucode_i = 48'({$urandom(), $urandom()});
            for (int l = 0; l < 2; l++) begin
                set_loop(l, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 8));
            end
            ro_reg_i = {$urandom(), $urandom(), $urandom()};
            offs_init_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_seq(1, 0);
            chk_idle("idle_after_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
